// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, valid/ready on both sides.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow flag output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload until then, and ready never depends combinationally on valid.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bit_d;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ br_q;
    br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_shift_w1
    assign res_shift = bit_d;
  end else begin : g_shift_wn
    assign res_shift = {bit_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done_valid  = (state_q == DONE);
  assign diff        = res_q;
  assign bout        = br_q;
  assign dbg_state   = state_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic beff_msb_q;
  logic ovf_q;
  logic b_eff_msb;

  // MSB of (b + bin) mod 2^WIDTH: bin carries into the MSB only when all lower bits of b are set.
  if (WIDTH == 1) begin : g_beff_w1
    assign b_eff_msb = b[0] ^ bin;
  end else begin : g_beff_wn
    assign b_eff_msb = b[WIDTH-1] ^ (bin & (&b[WIDTH-2:0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (state_q == IDLE && start_valid) begin
      a_msb_q    <= a[WIDTH-1];
      beff_msb_q <= b_eff_msb;
      ovf_q      <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= (a_msb_q != beff_msb_q) && (bit_d != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: randomized requests checked against an integer reference model.
module tb_serial_subtractor;

  localparam int W = 4;
`ifdef SERIAL_SUB_OVF_EN
  localparam int EW = W + 2;
`else
  localparam int EW = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;
  logic [1:0]   dbg_state;
  logic [EW-1:0] obs;

  logic         w1_start_valid = 1'b0;
  logic         w1_start_ready;
  logic [0:0]   w1_a = '0;
  logic [0:0]   w1_b = '0;
  logic         w1_bin = 1'b0;
  logic [0:0]   w1_diff;
  logic         w1_bout;
  logic         w1_done_valid;
  logic         w1_done_ready = 1'b1;
  logic         w1_busy;
  logic [1:0]   w1_dbg_state;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  logic w1_ovf;
  assign obs = {ovf, bout, diff};
`else
  assign obs = {bout, diff};
`endif

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .bin(bin), .diff(diff), .bout(bout), .done_valid(done_valid),
    .done_ready(done_ready), .busy(busy),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  serial_subtractor #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .start_valid(w1_start_valid), .start_ready(w1_start_ready),
    .a(w1_a), .b(w1_b), .bin(w1_bin), .diff(w1_diff), .bout(w1_bout), .done_valid(w1_done_valid),
    .done_ready(w1_done_ready), .busy(w1_busy),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(w1_ovf),
`endif
    .dbg_state(w1_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int unsigned   acc_q[$];
  logic          rand_rdy = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [EW-1:0] model(logic [W-1:0] av, logic [W-1:0] bv, logic binv);
    int r;
    logic [W-1:0] d;
    logic bo;
`ifdef SERIAL_SUB_OVF_EN
    int sa, sb, sd;
    logic [W-1:0] beff;
    logic ov;
`endif
    r  = int'(av) - int'(bv) - int'(binv);
    d  = W'(r);
    bo = (r < 0);
`ifdef SERIAL_SUB_OVF_EN
    beff = W'(int'(bv) + int'(binv));
    sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb = beff[W-1] ? int'(beff) - (1 << W) : int'(beff);
    sd = sa - sb;
    ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return {ov, bo, d};
`else
    return {bo, d};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) done_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
    int n;
    n = 0;
    while (!start_ready && n < 200) begin
      tick();
      n++;
    end
    if (!start_ready) begin
      errors++;
      $display("FAIL send_timeout: start_ready got 0 expected 1");
      return;
    end
    a = av;
    b = bv;
    bin = binv;
    start_valid = 1'b1;
    exp_q.push_back(model(av, bv, binv));
    tick();
    acc_q.push_back(cyc);
    start_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_valid) && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || done_valid) begin
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic run_w1(input logic av, input logic bv, input logic binv);
    int r;
    logic [2:0] e;
    r = int'(av) - int'(bv) - int'(binv);
    e[0] = 1'(r);
    e[1] = (r < 0);
    // W=1 signed range is [-1,0]; b folded with bin is 0 or -1.
    e[2] = ((av ? -1 : 0) - ((bv ^ binv) ? -1 : 0)) > 0;
    check("w1_start_ready", 32'(w1_start_ready), 32'd1);
    w1_a = av;
    w1_b = bv;
    w1_bin = binv;
    w1_start_valid = 1'b1;
    tick();
    w1_start_valid = 1'b0;
    check("w1_not_done_yet", 32'(w1_done_valid), 32'd0);
    tick();
    check("w1_done_valid", 32'(w1_done_valid), 32'd1);
    check("w1_result", 32'({w1_bout, w1_diff}), 32'(e[1:0]));
`ifdef SERIAL_SUB_OVF_EN
    check("w1_ovf", 32'(w1_ovf), 32'(e[2]));
`endif
    tick();
    check("w1_idle_again", 32'(w1_start_ready), 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic          prev_dv = 1'b0;
  logic          prev_rdy = 1'b0;
  logic [EW-1:0] prev_obs = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (done_valid && !prev_dv) begin
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done_valid got 1 expected 0");
        end else begin
          check("latency", 32'(cyc - acc_q[0]), 32'(W));
        end
      end
      if (done_valid && prev_dv && !prev_rdy) check("hold_stable", 32'(obs), 32'(prev_obs));
      if (done_valid) check("start_ready_in_done", 32'(start_ready), 32'd0);
      if (done_valid && done_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", obs);
        end else begin
          check("result", 32'(obs), 32'(exp_q.pop_front()));
        end
        if (acc_q.size() != 0) void'(acc_q.pop_front());
      end
      prev_dv  = done_valid;
      prev_rdy = done_ready;
      prev_obs = obs;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(obs), 32'd0);
    rst_n = 1'b1;
    done_ready = 1'b1;
    tick();

    // directed cases
    send(4'd9, 4'd3, 1'b0);
    drain();
    send(4'd3, 4'd9, 1'b0);
    drain();
    send(4'd0, 4'd0, 1'b1);
    drain();
    send(4'd8, 4'd1, 1'b0);
    send(4'd7, 4'd1, 1'b0);
    send(4'd0, 4'd8, 1'b0);
    drain();

    // backpressure: DONE must hold and ignore new requests
    done_ready = 1'b0;
    send(4'd5, 4'd2, 1'b0);
    n = 0;
    while (!done_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_reached_done", 32'(done_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      start_valid = 1'b1;
      tick();
      check("bp_busy", 32'(busy), 32'd1);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    check("bp_ready_after_hs", 32'(start_ready), 32'd1);
    check("bp_idle_not_busy", 32'(busy), 32'd0);

    // asynchronous reset in the middle of RUN
    a = 4'd5;
    b = 4'd3;
    bin = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done_valid", 32'(done_valid), 32'd0);
    check("mid_rst_result", 32'(obs), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(4'd5, 4'd5, 1'b0);
    drain();

    // corner operands, then random stream with random backpressure
    send(4'd15, 4'd0, 1'b0);
    send(4'd0, 4'd15, 1'b1);
    send(4'd15, 4'd15, 1'b1);
    send(4'd7, 4'd7, 1'b1);
    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_rdy = 1'b0;
    done_ready = 1'b1;

    // WIDTH=1 instance: every operand combination
    for (int i = 0; i < 8; i++) begin
      run_w1(i[0], i[1], i[2]);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
